// File: rtl/stack_machine_p.sv
// stack_machine_p: one-instruction-per-cycle stack machine with registered results,
// error reporting and a sticky finish flag.
module stack_machine_p #(
  parameter int OPW = 10,
  parameter int DW = 20,
  parameter int DEPTH = 8,
  parameter int PCW = 10,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPW+2:0]    instr,
  output logic [PCW-1:0]    pc,
  output logic              d_valid,
  output logic [DW-1:0]     out_data,
  output logic [2:0]        err_code,
  output logic [CW-1:0]     stack_cnt,
  output logic              fin
);
  typedef enum logic [2:0] {PUSH, ADD, SUB, MUL, POP, DUP, SWAP, HALT} op_e;
  localparam logic [2:0] E_OK = 3'd0, E_OVF = 3'd1, E_UNF = 3'd2, E_ARI = 3'd3;
  op_e op;
  logic [DW-1:0] stk_q [DEPTH];
  logic [PCW-1:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] out_q, out_d;
  logic [2:0] err_q, err_d;
  logic dv_q, dv_d, fin_q, fin_d;
  logic [AW-1:0] t_i, n_i, p_i, i0, i1;
  logic [DW-1:0] a, b, ext, res, d0, d1;
  logic [DW:0] sum, dif;
  logic signed [2*DW-1:0] prod;
  logic ovf, we0, we1, full, empty, lt2;
  assign op = op_e'(instr[OPW+2:OPW]);
  assign t_i = AW'(cnt_q - 1'b1);
  assign n_i = AW'(cnt_q - 2'd2);
  assign p_i = AW'(cnt_q);
  assign a = stk_q[n_i];
  assign b = stk_q[t_i];
  assign ext = {{(DW-OPW){instr[OPW-1]}}, instr[OPW-1:0]};
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign lt2 = cnt_q < CW'(2);
  // Exact results at full width; overflow when the upper bits are not a pure sign extension.
  assign sum = {a[DW-1], a} + {b[DW-1], b};
  assign dif = {a[DW-1], a} - {b[DW-1], b};
  assign prod = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
  assign res = op == ADD ? sum[DW-1:0] : op == SUB ? dif[DW-1:0] : prod[DW-1:0];
  assign ovf = op == ADD ? sum[DW] != sum[DW-1] :
               op == SUB ? dif[DW] != dif[DW-1] :
               !(&prod[2*DW-1:DW-1] || ~|prod[2*DW-1:DW-1]);
  always_comb begin
    pc_d = pc_q;
    cnt_d = cnt_q;
    out_d = out_q;
    err_d = err_q;
    dv_d = 1'b0;
    fin_d = fin_q;
    we0 = 1'b0;
    we1 = 1'b0;
    i0 = p_i;
    i1 = t_i;
    d0 = ext;
    d1 = a;
    if (!fin_q && op == HALT) begin
      fin_d = 1'b1;
    end else if (!fin_q) begin
      dv_d = 1'b1;
      err_d = E_OK;
      pc_d = pc_q == '1 ? pc_q : pc_q + 1'b1;
      fin_d = pc_q == '1;
      case (op)
        PUSH: begin
          out_d = ext;
          err_d = full ? E_OVF : E_OK;
          we0 = !full;
          cnt_d = full ? cnt_q : cnt_q + 1'b1;
        end
        DUP: begin
          out_d = empty ? '0 : b;
          err_d = empty ? E_UNF : full ? E_OVF : E_OK;
          we0 = !empty && !full;
          d0 = b;
          cnt_d = we0 ? cnt_q + 1'b1 : cnt_q;
        end
        POP: begin
          out_d = empty ? '0 : b;
          err_d = empty ? E_UNF : E_OK;
          cnt_d = empty ? cnt_q : cnt_q - 1'b1;
        end
        SWAP: begin
          out_d = lt2 ? '0 : a;
          err_d = lt2 ? E_UNF : E_OK;
          we0 = !lt2;
          we1 = !lt2;
          i0 = n_i;
          d0 = b;
        end
        default: begin
          out_d = lt2 ? '0 : res;
          err_d = lt2 ? E_UNF : ovf ? E_ARI : E_OK;
          we0 = !lt2 && !ovf;
          i0 = n_i;
          d0 = res;
          cnt_d = we0 ? cnt_q - 1'b1 : cnt_q;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
      err_q <= '0;
      dv_q <= 1'b0;
      fin_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      err_q <= err_d;
      dv_q <= dv_d;
      fin_q <= fin_d;
    end
  end
  // Stack storage needs no reset; stack_cnt alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (we0) stk_q[i0] <= d0;
    if (we1) stk_q[i1] <= d1;
  end
  assign pc = pc_q;
  assign stack_cnt = cnt_q;
  assign out_data = out_q;
  assign err_code = err_q;
  assign d_valid = dv_q;
  assign fin = fin_q;
endmodule

// File: tb/tb_stack_machine_p.sv
// tb_stack_machine_p: directed programs with a scoreboard queue and an independent monitor.
module tb_stack_machine_p;
  localparam logic [2:0] PUSH = 3'd0, ADD = 3'd1, SUB = 3'd2, MUL = 3'd3,
                         POP = 3'd4, DUP = 3'd5, SWAP = 3'd6, HALT = 3'd7;
  typedef struct {
    logic [19:0] o;
    logic [2:0]  e;
    logic [3:0]  c;
    logic [9:0]  p;
    bit          co;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [12:0] instr = {HALT, 10'd0};
  logic [9:0] pc;
  logic d_valid, fin;
  logic [19:0] out_data;
  logic [2:0] err_code;
  logic [3:0] stack_cnt;
  exp_t q[$];
  int checks = 0, errors = 0, n_seen = 0;
  logic [9:0] ep = '0;

  stack_machine_p dut (.clk(clk), .rst(rst), .instr(instr), .pc(pc), .d_valid(d_valid),
    .out_data(out_data), .err_code(err_code), .stack_cnt(stack_cnt), .fin(fin));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (!rst && d_valid) begin
      exp_t x;
      checks++;
      n_seen++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got out=%0h err=%0d cnt=%0d pc=%0d, expected no result",
          out_data, err_code, stack_cnt, pc);
      end else begin
        x = q.pop_front();
        if ((x.co && out_data !== x.o) || err_code !== x.e || stack_cnt !== x.c || pc !== x.p) begin
          errors++;
          $display("FAIL result#%0d: got out=%0h err=%0d cnt=%0d pc=%0d, expected out=%0h err=%0d cnt=%0d pc=%0d",
            n_seen, out_data, err_code, stack_cnt, pc, x.o, x.e, x.c, x.p);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [9:0] opd, input logic [19:0] o,
                       input logic [2:0] e, input logic [3:0] c, input bit co = 1'b1);
    instr = {op, opd};
    ep = ep == 10'h3FF ? ep : ep + 1'b1;
    q.push_back('{o, e, c, ep, co});
    @(negedge clk);
  endtask

  task automatic halt_idle();
    instr = {HALT, 10'd0};
    @(negedge clk);
  endtask

  task automatic do_reset();
    instr = {HALT, 10'd0};
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_cnt", 32'(stack_cnt), 0);
    chk("rst_flags", {d_valid, fin, err_code, out_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    ep = '0;
  endtask

  initial begin
    do_reset();
    // add
    issue(PUSH, 10'd5, 20'd5, 0, 1);
    issue(PUSH, 10'd3, 20'd3, 0, 2);
    issue(ADD, 10'd0, 20'd8, 0, 1);
    halt_idle();
    chk("halt_fin", 32'(fin), 1);
    chk("halt_pc", 32'(pc), 3);
    // sub and mul with negative operand
    do_reset();
    issue(PUSH, 10'd2, 20'd2, 0, 1);
    issue(PUSH, 10'd7, 20'd7, 0, 2);
    issue(SUB, 10'd0, 20'hFFFFB, 0, 1);
    issue(PUSH, 10'h3FF, 20'hFFFFF, 0, 2);
    issue(MUL, 10'd0, 20'd5, 0, 1);
    // overflow of the stack, then underflow after reset
    do_reset();
    for (int i = 1; i <= 8; i++) issue(PUSH, 10'd1, 20'd1, 0, 4'(i));
    issue(PUSH, 10'd1, 20'd0, 1, 8, 1'b0);
    do_reset();
    issue(ADD, 10'd0, 20'd0, 2, 0);
    // swap/dup/pop and underflow on each op
    do_reset();
    issue(PUSH, 10'd10, 20'd10, 0, 1);
    issue(PUSH, 10'h3FD, 20'hFFFFD, 0, 2);
    issue(SWAP, 10'd0, 20'd10, 0, 2);
    issue(DUP, 10'd0, 20'd10, 0, 3);
    issue(POP, 10'd0, 20'd10, 0, 2);
    issue(POP, 10'd0, 20'd10, 0, 1);
    issue(SUB, 10'd0, 20'd0, 2, 1);
    issue(SWAP, 10'd0, 20'd0, 2, 1);
    issue(POP, 10'd0, 20'hFFFFD, 0, 0);
    issue(POP, 10'd0, 20'd0, 2, 0);
    issue(DUP, 10'd0, 20'd0, 2, 0);
    // arithmetic overflow leaves the stack intact
    do_reset();
    issue(PUSH, 10'd511, 20'd511, 0, 1);
    issue(DUP, 10'd0, 20'd511, 0, 2);
    issue(MUL, 10'd0, 20'd261121, 0, 1);
    issue(PUSH, 10'd511, 20'd511, 0, 2);
    issue(MUL, 10'd0, 20'h405FF, 3, 2);
    issue(POP, 10'd0, 20'd511, 0, 1);
    issue(POP, 10'd0, 20'd261121, 0, 0);
    // program counter saturates at the last address and finishes
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      if (i % 2 == 0) issue(PUSH, 10'd1, 20'd1, 0, 1);
      else issue(POP, 10'd0, 20'd1, 0, 0);
    end
    chk("end_fin", 32'(fin), 1);
    chk("end_pc", 32'(pc), 32'h3FF);
    instr = {PUSH, 10'd5};
    @(negedge clk);
    chk("end_frozen_cnt", 32'(stack_cnt), 0);
    chk("end_frozen_dv", 32'(d_valid), 0);
    // halt freezes everything; asynchronous reset clears mid-cycle
    do_reset();
    issue(PUSH, 10'd4, 20'd4, 0, 1);
    halt_idle();
    instr = {PUSH, 10'd9};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("halted_dv", 32'(d_valid), 0);
    end
    chk("halted_fin", 32'(fin), 1);
    chk("halted_pc", 32'(pc), 1);
    chk("halted_cnt", 32'(stack_cnt), 1);
    chk("halted_out", 32'(out_data), 4);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_pc", 32'(pc), 0);
    chk("async_cnt", 32'(stack_cnt), 0);
    chk("async_flags", {d_valid, fin, err_code, out_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    ep = '0;
    issue(PUSH, 10'd6, 20'd6, 0, 1);
    halt_idle();
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
